// File: rtl/lat_cfg_pkg.sv
// Shared types and frame layout for the look-at-table configuration serializer.
package lat_cfg_pkg;

   // Frame geometry: five 5-bit jump states above a 2-bit clock-select field.
   localparam int unsigned LAT_FRAME_W    = 27;
   localparam int unsigned LAT_JUMP_W     = 5;
   localparam int unsigned LAT_CLKSEL_W   = 2;

   // Bit offsets of each field within the frame (LSB of the field).
   localparam int unsigned LAT_CLKSEL_OFS = 0;
   localparam int unsigned LAT_JUMP0_OFS  = 2;
   localparam int unsigned LAT_JUMP1_OFS  = 7;
   localparam int unsigned LAT_JUMP2_OFS  = 12;
   localparam int unsigned LAT_JUMP3_OFS  = 17;
   localparam int unsigned LAT_JUMP4_OFS  = 22;

   // Serializer control states.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SHIFT    = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_DONE     = 3'd3,
      ST_ERR      = 3'd4
   } lat_state_e;

   // Structured view of one transition-table frame; jump4 is sent first.
   typedef struct packed {
      logic [LAT_JUMP_W-1:0]   jump4;
      logic [LAT_JUMP_W-1:0]   jump3;
      logic [LAT_JUMP_W-1:0]   jump2;
      logic [LAT_JUMP_W-1:0]   jump1;
      logic [LAT_JUMP_W-1:0]   jump0;
      logic [LAT_CLKSEL_W-1:0] clk_sel;
   } lat_frame_t;

endpackage

// File: rtl/lat_cfg_shreg.sv
// Loadable left-shift register with bit counter; o_last flags the final frame bit.
module lat_cfg_shreg #(
   parameter int unsigned FRAME_W = 27
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               i_load,
   input  logic               i_shift,
   input  logic [FRAME_W-1:0] i_data,
   output logic               o_msb,
   output logic               o_last
);

   localparam int unsigned CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

   logic [FRAME_W-1:0] r_shreg;
   logic [CNT_W-1:0]   r_cnt;

   // Capture a new frame or shift one bit out MSB-first with zero fill.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (i_load) begin
         r_shreg <= i_data;
         r_cnt   <= '0;
      end else if (i_shift) begin
         r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
         r_cnt   <= r_cnt + CNT_W'(1);
      end
   end

   assign o_msb  = r_shreg[FRAME_W-1];
   assign o_last = (r_cnt == CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/lat_cfg_serializer.sv
// Accepts a parallel frame, shifts it out serially and waits for the core's acknowledge.
module lat_cfg_serializer
   import lat_cfg_pkg::*;
#(
   parameter int unsigned FRAME_W     = LAT_FRAME_W,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               load_valid,
   output logic               load_ready,
   input  logic [FRAME_W-1:0] load_data,
   input  logic               abort,
   input  logic               clear_err,
   output logic               ser_out,
   output logic               ser_en,
   input  logic               ack_in,
   output logic               busy,
   output logic               frame_done,
   output logic               err
);

   localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   lat_state_e       r_state;
   lat_state_e       w_state_nxt;
   logic [TO_W-1:0]  r_to_cnt;
   logic             r_err;
   logic             w_load;
   logic             w_shift;
   logic             w_err_set;
   logic             w_err_clr;
   logic             w_msb;
   logic             w_last;
   logic             w_to_last;

   lat_cfg_shreg #(
      .FRAME_W (FRAME_W)
   ) u_shreg (
      .clk     (clk),
      .nrst    (nrst),
      .i_load  (w_load),
      .i_shift (w_shift),
      .i_data  (load_data),
      .o_msb   (w_msb),
      .o_last  (w_last)
   );

   assign w_to_last = (r_to_cnt == TO_W'(ACK_TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and control decode; abort outranks acknowledge and timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_err_set   = 1'b0;
      w_err_clr   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_err) begin
               w_err_clr = clear_err;
            end else if (load_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_shift = 1'b1;
               if (w_last) begin
                  w_state_nxt = ST_WAIT_ACK;
               end
            end
         end
         ST_WAIT_ACK: begin
            if (abort) begin
               w_state_nxt = ST_IDLE;
            end else if (ack_in) begin
               w_state_nxt = ST_DONE;
            end else if (w_to_last) begin
               w_state_nxt = ST_ERR;
               w_err_set   = 1'b1;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Acknowledge timeout counter, held at zero outside WAIT_ACK so it restarts on entry.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_to_cnt <= '0;
      end else if (r_state != ST_WAIT_ACK) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   // Sticky timeout flag, cleared only from IDLE.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end else if (w_err_clr) begin
         r_err <= 1'b0;
      end
   end

   // Outputs decoded from registered state only.
   assign load_ready = (r_state == ST_IDLE) && !r_err;
   assign ser_en     = (r_state == ST_SHIFT);
   assign ser_out    = (r_state == ST_SHIFT) && w_msb;
   assign busy       = (r_state == ST_SHIFT) || (r_state == ST_WAIT_ACK) || (r_state == ST_DONE);
   assign frame_done = (r_state == ST_DONE);
   assign err        = r_err;

endmodule

// File: tb/tb_lat_cfg_serializer.sv
// Self-checking bench for lat_cfg_serializer with a frame-level timing model.
module tb_lat_cfg_serializer;
   import lat_cfg_pkg::*;

   localparam int FW = LAT_FRAME_W;
   localparam int T  = 8;

   logic          clk = 1'b0;
   logic          nrst;
   logic          load_valid;
   logic          load_ready;
   logic [FW-1:0] load_data;
   logic          abort;
   logic          clear_err;
   logic          ser_out;
   logic          ser_en;
   logic          ack_in;
   logic          busy;
   logic          frame_done;
   logic          err;

   int n_checks = 0;
   int n_fail   = 0;
   bit m_err    = 1'b0;

   always #5 clk = ~clk;

   lat_cfg_serializer #(
      .FRAME_W     (FW),
      .ACK_TIMEOUT (T)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .abort      (abort),
      .clear_err  (clear_err),
      .ser_out    (ser_out),
      .ser_en     (ser_en),
      .ack_in     (ack_in),
      .busy       (busy),
      .frame_done (frame_done),
      .err        (err)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_outs(input string ph, input logic e_en, input logic e_so, input logic e_bsy,
                           input logic e_fd, input logic e_lr, input logic e_er);
      chk({ph, ".ser_en"},     32'(ser_en),     32'(e_en));
      chk({ph, ".ser_out"},    32'(ser_out),    32'(e_so));
      chk({ph, ".busy"},       32'(busy),       32'(e_bsy));
      chk({ph, ".frame_done"}, 32'(frame_done), 32'(e_fd));
      chk({ph, ".load_ready"}, 32'(load_ready), 32'(e_lr));
      chk({ph, ".err"},        32'(err),        32'(e_er));
   endtask

   // One frame: ack_in driven high from cycle ack_start (-1: never), abort driven in
   // cycle abort_at, nrst pulsed in cycle rst_at; hold keeps load_valid high throughout.
   // Cycle c runs from handshake edge E(c) to E(c+1); outputs are sampled at negedge.
   task automatic run_frame(input logic [FW-1:0] data, input int ack_start, input int abort_at,
                            input int rst_at, input bit hold);
      int w_ack;
      int wdur;
      int last;
      bit ack_ok;
      w_ack  = (ack_start < FW) ? 0 : ack_start - FW;
      ack_ok = (ack_start >= 0) && (w_ack <= T - 1);
      wdur   = ack_ok ? w_ack + 1 : T;
      last   = (abort_at >= 0) ? abort_at + 1 : FW + wdur + 1;
      chk("pre.load_ready", 32'(load_ready), 32'(1));
      load_valid = 1'b1;
      load_data  = data;
      @(negedge clk);
      for (int c = 0; c <= last; c++) begin
         if (abort_at >= 0 && c > abort_at) begin
            chk_outs("abort_idle", 0, 0, 0, 0, !m_err, m_err);
         end else if (c < FW) begin
            chk_outs($sformatf("shift%0d", c), 1, data[FW-1-c], 1, 0, 0, m_err);
         end else if (c < FW + wdur) begin
            chk_outs($sformatf("wait%0d", c - FW), 0, 0, 1, 0, 0, m_err);
         end else if (c == FW + wdur) begin
            if (ack_ok) begin
               chk_outs("done", 0, 0, 1, 1, 0, m_err);
            end else begin
               m_err = 1'b1;
               chk_outs("err", 0, 0, 0, 0, 0, 1);
            end
         end else begin
            chk_outs("idle", 0, 0, 0, 0, !m_err, m_err);
         end
         if (c == rst_at) begin
            #2 nrst = 1'b0;
            #1;
            m_err = 1'b0;
            chk_outs("async_rst", 0, 0, 0, 0, 1, 0);
            @(negedge clk);
            nrst       = 1'b1;
            load_valid = 1'b0;
            ack_in     = 1'b0;
            abort      = 1'b0;
            return;
         end
         if (c < last) begin
            load_valid = hold;
            load_data  = FW'($urandom);
            ack_in     = (ack_start >= 0) && (c >= ack_start);
            abort      = (c == abort_at);
            @(negedge clk);
         end
      end
      ack_in     = 1'b0;
      abort      = 1'b0;
      load_valid = hold;
   endtask

   // While err is set no frame is accepted; clear_err re-opens load_ready the next cycle.
   task automatic clear_err_seq();
      load_valid = 1'b1;
      load_data  = FW'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk_outs("err_blocked", 0, 0, 0, 0, 0, 1);
      end
      load_valid = 1'b0;
      clear_err  = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      m_err     = 1'b0;
      chk_outs("err_cleared", 0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      nrst       = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      abort      = 1'b0;
      clear_err  = 1'b0;
      ack_in     = 1'b0;
      #12;
      chk_outs("in_reset", 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      chk_outs("after_reset", 0, 0, 0, 0, 1, 0);

      // Nominal frame, ack already high when WAIT_ACK starts.
      run_frame(27'h5A5_A5A5, FW - 1, -1, -1, 0);
      // No acknowledge: timeout, sticky err, then clear.
      run_frame(27'h123_4567, -1, -1, -1, 0);
      clear_err_seq();
      // Abort at bit index 10 of the shift, then a fresh frame goes out intact.
      run_frame(27'h7FF_FFFF, -1, 10, -1, 0);
      run_frame(27'h000_0001, FW - 1, -1, -1, 0);
      // Ack arriving exactly on the timeout cycle wins; one cycle later is a timeout.
      run_frame(27'h4C3_2A19, FW + T - 1, -1, -1, 0);
      run_frame(27'h1F0_F0F0, FW + T, -1, -1, 0);
      clear_err_seq();
      // Abort while waiting for acknowledge.
      run_frame(27'h2DB_6DB6, -1, FW + 2, -1, 0);
      // Asynchronous reset mid-shift, then a clean frame.
      run_frame(27'h3C3_C3C3, FW - 1, -1, 5, 0);
      run_frame(27'h2AA_AAAA, FW + 3, -1, -1, 0);
      // Back-to-back with load_valid held high.
      run_frame(27'h654_3210, FW + 2, -1, -1, 1);
      run_frame(27'h0F0_F00F, FW - 1, -1, -1, 0);

      // Randomized frames.
      for (int i = 0; i < 25; i++) begin
         int sel;
         int a_start;
         int a_at;
         sel     = int'($urandom_range(0, 9));
         a_start = (sel < 2) ? -1 : int'($urandom_range(0, FW + T + 2));
         a_at    = (sel == 9) ? int'($urandom_range(0, FW)) : -1;
         run_frame(FW'($urandom), a_start, a_at, -1, 0);
         if (m_err) begin
            clear_err_seq();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lat_cfg_serializer.md
# lat_cfg_serializer

Upstream configuration source for the look-at-table FSM core. Accepts one parallel transition-table frame through a valid/ready handshake, shifts it out MSB-first on a single serial line into the core's serial state-register input, then waits for the core's load-finished flag. Reports completion, or a timeout error if the core never acknowledges.

## Interface
- `FRAME_W`, 27: frame width in bits (five 5-bit jump states plus 2 clock-select bits).
- `ACK_TIMEOUT`, 64: maximum cycles to wait for `ack_in` after the last bit.
- `clk`  in  1  system clock; all state changes on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  `load_data` holds a frame to send.
- `load_ready`  out  1  block can accept a frame.
- `load_data`  in  FRAME_W  parallel frame; bit FRAME_W-1 is sent first.
- `abort`  in  1  synchronous cancel of the frame in flight.
- `clear_err`  in  1  clears sticky `err`.
- `ser_out`  out  1  serial data to the core's serial state input.
- `ser_en`  out  1  high on every cycle where `ser_out` carries a valid frame bit.
- `ack_in`  in  1  core's load-finished flag (level).
- `busy`  out  1  a frame is being sent or acknowledged.
- `frame_done`  out  1  one-cycle pulse on successful acknowledge.
- `err`  out  1  sticky flag: acknowledge timeout.

## Operation
- States: IDLE, SHIFT, WAIT_ACK, DONE, ERR.
- IDLE: `load_ready`=1 if `err`=0. On `load_valid & load_ready`, capture `load_data` into the shift register, clear the bit counter, and go to SHIFT.
- SHIFT: `ser_out`=shreg[FRAME_W-1], `ser_en`=1. The register shifts left by one each cycle with zero fill, and the counter increments. After the cycle with counter = FRAME_W-1, go to WAIT_ACK.
- WAIT_ACK: `ser_en`=0, `ser_out`=0. The timeout counter increments each cycle.
  - If `ack_in`=1, go to DONE.
  - Otherwise, when the counter reaches ACK_TIMEOUT-1, go to ERR.
  - If `ack_in` rises in the same cycle the timeout is reached, `ack_in` wins.
- DONE: `frame_done`=1 for exactly one cycle, then IDLE.
- ERR: set `err`=1 and return to IDLE. `load_ready` stays 0 until `clear_err`. `clear_err` in IDLE clears `err`; the next cycle `load_ready`=1.
- `abort`, in SHIFT or WAIT_ACK, returns to IDLE next cycle:
  - `ser_en` drops immediately on that edge.
  - No `frame_done` pulse, and `err` is unchanged.
  - `abort` in IDLE, DONE or ERR is ignored.
- `busy`=1 in SHIFT, WAIT_ACK and DONE; 0 otherwise.
- `ack_in` is ignored outside WAIT_ACK. If `ack_in` is already high on entry to WAIT_ACK, that counts as an acknowledge in the first WAIT_ACK cycle.
- Bit counter width is clog2(FRAME_W); timeout counter width is clog2(ACK_TIMEOUT). Neither counter wraps: each is cleared on entry to its state.

## Timing
- Reset values: `load_ready`=1, `ser_out`=0, `ser_en`=0, `busy`=0, `frame_done`=0, `err`=0. The state is IDLE and both counters are 0.
- Handshake at edge E0 puts bit FRAME_W-1 on `ser_out` from E0 until E1. Bit k is valid between edges E(FRAME_W-1-k) and E(FRAME_W-k).
- The last bit (bit 0) is held until edge E(FRAME_W). WAIT_ACK starts then.
- `ack_in` sampled high at edge Ea puts the block in DONE after Ea (`frame_done`=1). IDLE follows at Ea+1.
- Minimum frame-to-frame spacing is FRAME_W+2 cycles, because `load_ready`=0 from E0 until DONE exits.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- `nrst` assertion at any point forces the reset values asynchronously. Any partial frame is discarded.

## Structure
- Shared package `lat_cfg_pkg`:
  - state enum (IDLE, SHIFT, WAIT_ACK, DONE, ERR);
  - `LAT_FRAME_W`=27;
  - field offsets of the five 5-bit jump states and the 2-bit clock-select field within the frame.
- One sub-module, `lat_cfg_shreg`: a loadable FRAME_W-bit left-shift register with the bit counter and a `last` flag. The FSM and the timeout counter live in the top module.

## Test plan
- Reset, then load 27'h5A5_A5A5 with `ack_in` tied high after 27 cycles.
  - `ser_out` sequence equals the frame MSB-first.
  - `ser_en` is high for exactly 27 cycles.
  - `frame_done` pulses once at cycle 28 or later; `busy` falls one cycle later.
- No ack, ACK_TIMEOUT=8.
  - `err` sets 8 cycles after the last bit, and `load_ready` stays 0.
  - Pulse `clear_err`: `load_ready`=1 next cycle.
- `abort` asserted at bit 10 of frame 27'h7FF_FFFF.
  - `ser_en` is 0 the next cycle, with no `frame_done` and `err`=0.
  - A fresh frame 27'h000_0001 is accepted and sent intact.
- `ack_in` rises exactly on the timeout cycle: `frame_done`=1 and `err`=0.
- `nrst` pulsed low mid-SHIFT at bit 5: all outputs are at reset values immediately, and the next frame serializes correctly.
- Back-to-back `load_valid` held high with two frames: the second handshake occurs only in the cycle after the first `frame_done`, with no bit overlap.
